// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit.
package bru_pkg;
  localparam int BRU_XLEN = 32;
  localparam int PC_STEP  = 4;

  typedef enum logic {RUN, RECOVER} bru_state_e;

  typedef struct packed {
    logic [BRU_XLEN-1:0] pc;
    logic                pred_taken;
    logic [BRU_XLEN-1:0] pred_target;
  } bru_entry_t;
endpackage

// File: rtl/bru_fifo.sv
// In-order queue of in-flight branch predictions; clear drops every entry at once.
module bru_fifo import bru_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       clear,
  input  bru_entry_t din,
  output bru_entry_t head,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  bru_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk)
    if (push && !clear) mem[wr_ptr] <= din;
endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves fetch-time predictions against execute outcomes, redirects and flushes on mispredict.
// Optional BRU_PERF_CNT_EN adds branch / mispredict counters.
module branch_resolve_unit import bru_pkg::*; #(
  parameter int XLEN  = BRU_XLEN,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_valid,
  output logic            push_ready,
  input  logic [XLEN-1:0] push_pc,
  input  logic            push_pred_taken,
  input  logic [XLEN-1:0] push_pred_target,
  input  logic            res_valid,
  output logic            res_ready,
  input  logic            res_taken,
  input  logic [XLEN-1:0] res_target,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_f1_f2_ppreg,
  output logic            flush_f2_d_ppreg,
  output logic            flush_d_e_ppreg,
  output logic            upd_valid,
  output logic            upd_taken
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
`endif
);
  bru_state_e state, state_nxt;
  bru_entry_t din, head;
  logic       full, empty;
  logic       push_fire, res_fire, mispredict, mis_fire;
  logic [XLEN-1:0] correct_pc;

  assign push_ready = !full  && (state == RUN);
  assign res_ready  = !empty && (state == RUN);
  assign push_fire  = push_valid && push_ready;
  assign res_fire   = res_valid  && res_ready;

  assign mispredict = (head.pred_taken != res_taken) ||
                      (res_taken && (head.pred_target != res_target));
  assign mis_fire   = res_fire && mispredict;
  assign correct_pc = res_taken ? res_target : head.pc + XLEN'(PC_STEP);

  assign din = '{pc: push_pc, pred_taken: push_pred_taken, pred_target: push_pred_target};

  // A push alongside a mispredict is on the wrong path, so it never enters the queue.
  bru_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_fire && !mis_fire),
    .pop   (res_fire && !mis_fire),
    .clear (mis_fire),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk)
    if (rst) state <= RUN;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (mis_fire) state_nxt = RECOVER;
      RECOVER: state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid    <= 1'b0;
      redirect_pc       <= '0;
      flush_f1_f2_ppreg <= 1'b0;
      flush_f2_d_ppreg  <= 1'b0;
      flush_d_e_ppreg   <= 1'b0;
      upd_valid         <= 1'b0;
      upd_taken         <= 1'b0;
    end else begin
      redirect_valid    <= mis_fire;
      flush_f1_f2_ppreg <= mis_fire;
      flush_f2_d_ppreg  <= mis_fire;
      flush_d_e_ppreg   <= mis_fire;
      upd_valid         <= res_fire;
      upd_taken         <= res_fire && res_taken;
      if (mis_fire) redirect_pc <= correct_pc;
    end
  end

`ifdef BRU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (res_fire) perf_branches    <= perf_branches + 32'd1;
      if (mis_fire) perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`endif

  // Execute must not present a resolve when nothing is outstanding.
  a_res_empty: assert property (@(posedge clk) disable iff (rst)
    !(res_valid && empty && state == RUN));
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            push_valid, push_ready, push_pred_taken;
  logic [XLEN-1:0] push_pc, push_pred_target;
  logic            res_valid, res_ready, res_taken;
  logic [XLEN-1:0] res_target;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush_f1_f2_ppreg, flush_f2_d_ppreg, flush_d_e_ppreg;
  logic            upd_valid, upd_taken;
`ifdef BRU_PERF_CNT_EN
  logic [31:0]     perf_branches, perf_mispredicts;
`endif

  int tests = 0;
  int fails = 0;

  branch_resolve_unit #(.XLEN(XLEN), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
    .push_pred_taken(push_pred_taken), .push_pred_target(push_pred_target),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
    .res_target(res_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_f1_f2_ppreg(flush_f1_f2_ppreg), .flush_f2_d_ppreg(flush_f2_d_ppreg),
    .flush_d_e_ppreg(flush_d_e_ppreg),
    .upd_valid(upd_valid), .upd_taken(upd_taken)
`ifdef BRU_PERF_CNT_EN
    , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [XLEN-1:0] pc, input logic pt, input logic [XLEN-1:0] tgt);
    push_valid = 1'b1; push_pc = pc; push_pred_taken = pt; push_pred_target = tgt;
  endtask

  task automatic resolve(input logic tk, input logic [XLEN-1:0] tgt);
    res_valid = 1'b1; res_taken = tk; res_target = tgt;
  endtask

  task automatic idle();
    push_valid = 1'b0; res_valid = 1'b0;
  endtask

  // flags packed as {redirect_valid, f1f2, f2d, de, upd_valid, upd_taken}
  function automatic logic [5:0] flags();
    return {redirect_valid, flush_f1_f2_ppreg, flush_f2_d_ppreg, flush_d_e_ppreg,
            upd_valid, upd_taken};
  endfunction

  initial begin
    rst = 1'b1;
    push_pc = '0; push_pred_taken = 1'b0; push_pred_target = '0;
    res_taken = 1'b0; res_target = '0;
    idle();
    tick(); tick();
    chk("rst_flags", flags(), 6'b000000);
    chk("rst_redirect_pc", redirect_pc, 0);
    rst = 1'b0;
    tick();
    chk("rst_ready", {push_ready, res_ready}, 2'b10);

    // 1: correct not-taken
    push(32'h100, 1'b0, 32'h0); tick(); idle();
    chk("t1_res_ready", res_ready, 1);
    resolve(1'b0, 32'h0); tick(); idle();
    chk("t1_flags", flags(), 6'b000010);
    chk("t1_empty", res_ready, 0);
    tick();
    chk("t1_pulse_end", flags(), 6'b000000);

    // 2: predicted not-taken, actually taken; concurrent push is wrong-path
    push(32'h100, 1'b0, 32'h0); tick(); idle();
    resolve(1'b1, 32'h200); push(32'h999, 1'b0, 32'h0); tick(); idle();
    chk("t2_flags", flags(), 6'b111111);
    chk("t2_redirect_pc", redirect_pc, 32'h200);
    chk("t2_recover_ready", {push_ready, res_ready}, 2'b00);
    tick();
    chk("t2_pulse_end", flags(), 6'b000000);
    chk("t2_queue_empty", {push_ready, res_ready}, 2'b10);

    // 3: predicted taken, actually not-taken -> fall-through
    push(32'h300, 1'b1, 32'h400); tick(); idle();
    resolve(1'b0, 32'h0); tick(); idle();
    chk("t3_flags", flags(), 6'b111110);
    chk("t3_redirect_pc", redirect_pc, 32'h304);
    tick();

    // 4: taken with wrong target, then taken with right target
    push(32'h500, 1'b1, 32'h400); tick(); idle();
    resolve(1'b1, 32'h480); tick(); idle();
    chk("t4_redirect_pc", redirect_pc, 32'h480);
    chk("t4_flags", flags(), 6'b111111);
    tick();
    push(32'h600, 1'b1, 32'h400); tick(); idle();
    resolve(1'b1, 32'h400); tick(); idle();
    chk("t4_correct_taken", flags(), 6'b000011);

    // 5: fill, full behaviour, simultaneous push/resolve, flush with 3 younger
    push(32'h10, 1'b0, 32'h0);   tick();
    push(32'h20, 1'b0, 32'h0);   tick();
    push(32'h30, 1'b1, 32'h700); tick();
    push(32'h40, 1'b0, 32'h0);   tick(); idle();
    chk("t5_full", {push_ready, res_ready}, 2'b01);
    push(32'h99, 1'b0, 32'h0); resolve(1'b0, 32'h0); tick(); idle();
    chk("t5_full_resolve", flags(), 6'b000010);
    chk("t5_slot_freed", {push_ready, res_ready}, 2'b11);
    push(32'h50, 1'b0, 32'h0); resolve(1'b0, 32'h0); tick(); idle();
    chk("t5_push_pop_same", {push_ready, res_ready}, 2'b11);
    push(32'h60, 1'b0, 32'h0); tick(); idle();
    chk("t5_full_again", {push_ready, res_ready}, 2'b01);
    resolve(1'b0, 32'h0); push(32'h70, 1'b0, 32'h0); tick(); idle();
    chk("t5_flush_flags", flags(), 6'b111110);
    chk("t5_head_pc", redirect_pc, 32'h34);
    tick();
    chk("t5_queue_cleared", {push_ready, res_ready}, 2'b10);

    // 6: PC wrap on fall-through
    push(32'hFFFF_FFFC, 1'b1, 32'h8); tick(); idle();
    resolve(1'b0, 32'h0); tick(); idle();
    chk("t6_wrap_pc", redirect_pc, 32'h0);
    tick();
`ifdef BRU_PERF_CNT_EN
    chk("t6_perf_branches", perf_branches, 9);
    chk("t6_perf_mispredicts", perf_mispredicts, 5);
`endif

    // reset mid-queue with a mispredicting resolve pending
    push(32'h200, 1'b0, 32'h0); tick();
    push(32'h204, 1'b0, 32'h0); tick(); idle();
    resolve(1'b1, 32'h999); rst = 1'b1; tick(); idle();
    chk("rst_mid_flags", flags(), 6'b000000);
    chk("rst_mid_pc", redirect_pc, 0);
    rst = 1'b0;
    tick();
    chk("rst_mid_flags_after", flags(), 6'b000000);
    chk("rst_mid_queue", {push_ready, res_ready}, 2'b10);
`ifdef BRU_PERF_CNT_EN
    chk("rst_perf", {perf_branches, perf_mispredicts}, 64'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
